// File: rtl/switch_led_toggle.sv
// Four-channel push-button front end: synchronise, debounce, and toggle an LED
// plus pulse an event bit on every debounced release.
module switch_led_toggle #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [3:0] o_Switch_Event
);

    localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       db;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       led;
    logic [3:0]       sw_event;

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    // Each channel counts consecutive cycles of disagreement between the
    // synchronised input and its debounced state; only an unbroken run of
    // DEBOUNCE_LIMIT cycles commits the change.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync1    <= '0;
            sync2    <= '0;
            db       <= '0;
            led      <= '0;
            sw_event <= '0;
            for (int n = 0; n < 4; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int n = 0; n < 4; n++) begin
                sw_event[n] <= 1'b0;
                if (sync2[n] == db[n]) begin
                    cnt[n] <= '0;
                end else if (cnt[n] == CNT_MAX) begin
                    db[n]  <= sync2[n];
                    cnt[n] <= '0;
                    // Committing a 1 -> 0 transition is a release.
                    if (db[n]) begin
                        sw_event[n] <= 1'b1;
                        led[n]      <= ~led[n];
                    end
                end else begin
                    cnt[n] <= cnt[n] + CNT_ONE;
                end
            end
        end
    end

    assign o_LED_1        = led[0];
    assign o_LED_2        = led[1];
    assign o_LED_3        = led[2];
    assign o_LED_4        = led[3];
    assign o_Switch_Event = sw_event;

endmodule

// File: tb/tb_switch_led_toggle.sv
// Bench for switch_led_toggle: directed scenarios plus random switch activity,
// each cycle compared against a window-based reference of the debounce rules.
module tb_switch_led_toggle;

    localparam int L = 4;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst = 1'b0;
    logic [3:0] sw = 4'b0000;
    logic [3:0] led;
    logic [3:0] ev;

    int n_checks = 0;
    int n_errors = 0;
    int ev_cnt = 0;
    logic [3:0] ev_or = 4'b0000;

    // reference state: debounced level, LEDs, event, and raw samples per edge
    logic [3:0] m_db;
    logic [3:0] m_led;
    logic [3:0] m_ev;
    logic [3:0] hist[$];

    switch_led_toggle #(.DEBOUNCE_LIMIT(L)) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Switch_1     (sw[0]),
        .i_Switch_2     (sw[1]),
        .i_Switch_3     (sw[2]),
        .i_Switch_4     (sw[3]),
        .o_LED_1        (led[0]),
        .o_LED_2        (led[1]),
        .o_LED_3        (led[2]),
        .o_LED_4        (led[3]),
        .o_Switch_Event (ev)
    );

    // clock/reset block
    always #5 clk = clk_en ? ~clk : 1'b0;

    task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_db  = '0;
        m_led = '0;
        m_ev  = '0;
        hist.delete();
        repeat (L + 2) hist.push_back(4'b0000);
    endtask

    // The level seen by the debouncer at an edge is the raw value sampled two
    // edges earlier; the level flips when the last L such values all differ.
    task automatic model_edge(input logic [3:0] raw);
        bit stable;
        hist.push_back(raw);
        if (hist.size() > L + 3) void'(hist.pop_front());
        m_ev = '0;
        for (int n = 0; n < 4; n++) begin
            stable = 1'b1;
            for (int j = 0; j < L; j++) begin
                if (hist[hist.size() - 3 - j][n] == m_db[n]) stable = 1'b0;
            end
            if (stable) begin
                m_db[n] = ~m_db[n];
                if (m_db[n] == 1'b0) begin
                    m_ev[n]  = 1'b1;
                    m_led[n] = ~m_led[n];
                end
            end
        end
    endtask

    // driver: one clock edge, then compare against the reference
    task automatic tick(input string tag);
        logic [3:0] raw;
        logic r;
        raw = sw;
        r = rst;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else model_edge(raw);
        check({tag, "_led"}, led, m_led);
        check({tag, "_ev"}, ev, m_ev);
        ev_or = ev_or | ev;
        if (ev != 4'b0000) ev_cnt++;
    endtask

    task automatic hold(input int n, input string tag);
        repeat (n) tick(tag);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check({tag, "_async_led"}, led, 4'b0000);
        check({tag, "_async_ev"}, ev, 4'b0000);
        hold(2, tag);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        rst = 1'b1;
        #1;
        check("reset_led", led, 4'b0000);
        check("reset_ev", ev, 4'b0000);
        hold(2, "reset");
        rst = 1'b0;
        hold(3, "idle");

        // clean press/release on switch 1
        sw[0] = 1'b1;
        ev_cnt = 0;
        hold(10, "sw1_press");
        check("sw1_press_noev", 4'(ev_cnt), 4'd0);
        check("sw1_press_led", led, 4'b0000);
        sw[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick("sw1_rel");
            if (i == 5) check("sw1_ev_k5", ev, 4'b0000);
            if (i == 6) begin
                check("sw1_ev_k6", ev, 4'b0001);
                check("sw1_led_k6", led, 4'b0001);
            end
            if (i == 7) check("sw1_ev_k7", ev, 4'b0000);
        end

        // bounce rejection on switch 2
        ev_or = '0;
        repeat (4) begin
            sw[1] = 1'b1;
            hold(3, "bounce_hi");
            sw[1] = 1'b0;
            hold(1, "bounce_lo");
        end
        hold(10, "bounce_tail");
        check("bounce_noev", ev_or, 4'b0000);
        check("bounce_led", led, 4'b0001);

        // simultaneous release on all switches, twice
        pulse_reset("sim_rst");
        for (int rep = 0; rep < 2; rep++) begin
            sw = 4'b1111;
            hold(10, "sim_press");
            sw = 4'b0000;
            ev_cnt = 0;
            ev_or = '0;
            hold(10, "sim_rel");
            check("sim_ev_cnt", 4'(ev_cnt), 4'd1);
            check("sim_ev_bits", ev_or, 4'b1111);
            check("sim_led", led, (rep == 0) ? 4'b1111 : 4'b0000);
        end

        // reset in the middle of a release debounce on switch 3
        sw[2] = 1'b1;
        hold(10, "sw3_press");
        sw[2] = 1'b0;
        ev_or = '0;
        hold(3, "sw3_rel");
        pulse_reset("sw3_rst");
        hold(10, "sw3_after");
        check("sw3_killed_ev", ev_or, 4'b0000);
        check("sw3_killed_led", led, 4'b0000);
        sw[2] = 1'b1;
        hold(10, "sw3_press2");
        sw[2] = 1'b0;
        hold(6, "sw3_rel2");
        check("sw3_led_nominal", led, 4'b0100);

        // switch 4 held through reset deassertion
        sw[3] = 1'b1;
        pulse_reset("sw4_rst");
        ev_or = '0;
        hold(12, "sw4_held");
        check("sw4_held_noev", ev_or, 4'b0000);
        sw[3] = 1'b0;
        ev_cnt = 0;
        ev_or = '0;
        hold(10, "sw4_rel");
        check("sw4_ev_cnt", 4'(ev_cnt), 4'd1);
        check("sw4_ev_bits", ev_or, 4'b1000);
        check("sw4_led", led, 4'b1000);

        // random switch activity with random hold lengths
        for (int seg = 0; seg < 120; seg++) begin
            sw = 4'($urandom_range(0, 15));
            hold($urandom_range(1, 7), "rand");
        end
        sw = 4'b0000;
        hold(10, "rand_settle");
        if (m_led == 4'b0000) begin
            sw[0] = 1'b1;
            hold(10, "fill_press");
            sw[0] = 1'b0;
            hold(10, "fill_rel");
        end

        // asynchronous reset with the clock stopped
        clk_en = 1'b0;
        #23;
        check("stopped_led_before", led, m_led);
        rst = 1'b1;
        #1;
        check("stopped_rst_led", led, 4'b0000);
        check("stopped_rst_ev", ev, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
